// File: rtl/sram_writer.sv
// sram_writer: page writer for the external serial SRAM.
// Takes a page number and byte count, then streams an SPI WRITE frame
// (command, 24-bit address, data) through the shared byte-level SPI master.
// The first transaction after reset is preceded by a WRMR frame that puts the
// SRAM into sequential mode. Data bytes come from a valid/ack source.
module sram_writer #(
    parameter int unsigned PAGE_BITS = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] page_no,
    input  logic [7:0]  nbytes,
    input  logic        start,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        i_ack,
    output logic        busy,
    output logic        done,
    input  logic        spi_tx_ready,
    output logic        spi_tx_valid,
    output logic [7:0]  spi_tx_byte,
    output logic [6:0]  spi_tx_count
);

    localparam int unsigned PageBytes = 1 << PAGE_BITS;
    localparam logic [7:0]  PageBytes8 = 8'(PageBytes);

    localparam logic [7:0] CmdWrmr    = 8'h01;
    localparam logic [7:0] ModeSeq    = 8'h40;
    localparam logic [7:0] CmdWrite   = 8'h02;
    localparam logic [6:0] WrmrCount  = 7'd2;
    localparam logic [6:0] HeaderLen  = 7'd4;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StMode,
        StCmd,
        StAddrH,
        StAddrM,
        StAddrL,
        StData,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [6:0]  len_q, len_d;
    logic [6:0]  rem_q, rem_d;
    logic        mode_set_q, mode_set_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic [6:0]  count_q, count_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]  n_eff;
    logic [23:0] start_addr;
    logic        tx_go;

    // Clamp the request to one page and form the page base address.
    always_comb begin
        n_eff      = (nbytes > PageBytes8) ? PageBytes8 : nbytes;
        start_addr = {8'h00, 16'(page_no << PAGE_BITS)};
    end

    // The master drops ready only the cycle after it accepts, so a byte still
    // being offered must not count as a fresh ready; this keeps valid a pulse.
    assign tx_go = spi_tx_ready && !valid_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rem_d      = rem_q;
        mode_set_d = mode_set_q;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        count_d    = count_q;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (n_eff == 8'd0) begin
                        // Empty request: complete without touching the bus.
                        done_d = 1'b1;
                    end else begin
                        addr_d  = start_addr;
                        len_d   = n_eff[6:0];
                        rem_d   = n_eff[6:0];
                        busy_d  = 1'b1;
                        state_d = StStart;
                    end
                end
            end

            StStart: begin
                if (tx_go) begin
                    valid_d = 1'b1;
                    if (!mode_set_q) begin
                        byte_d  = CmdWrmr;
                        count_d = WrmrCount;
                        state_d = StMode;
                    end else begin
                        byte_d  = CmdWrite;
                        count_d = len_q + HeaderLen;
                        state_d = StAddrH;
                    end
                end
            end

            StMode: begin
                if (tx_go) begin
                    valid_d    = 1'b1;
                    byte_d     = ModeSeq;
                    mode_set_d = 1'b1;
                    state_d    = StCmd;
                end
            end

            StCmd: begin
                if (tx_go) begin
                    valid_d = 1'b1;
                    byte_d  = CmdWrite;
                    count_d = len_q + HeaderLen;
                    state_d = StAddrH;
                end
            end

            StAddrH: begin
                if (tx_go) begin
                    valid_d = 1'b1;
                    byte_d  = addr_q[23:16];
                    state_d = StAddrM;
                end
            end

            StAddrM: begin
                if (tx_go) begin
                    valid_d = 1'b1;
                    byte_d  = addr_q[15:8];
                    state_d = StAddrL;
                end
            end

            StAddrL: begin
                if (tx_go) begin
                    valid_d = 1'b1;
                    byte_d  = addr_q[7:0];
                    state_d = StData;
                end
            end

            StData: begin
                // Stalls with chip select held while the source has no data.
                if (tx_go && i_valid) begin
                    valid_d = 1'b1;
                    byte_d  = i_byte;
                    ack_d   = 1'b1;
                    rem_d   = rem_q - 7'd1;
                    if (rem_q == 7'd1) begin
                        state_d = StDrain;
                    end
                end
            end

            StDrain: begin
                // Ready returning after the last byte means it has shifted out.
                if (tx_go) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= 24'h0;
            len_q      <= 7'd0;
            rem_q      <= 7'd0;
            mode_set_q <= 1'b0;
            valid_q    <= 1'b0;
            byte_q     <= 8'h00;
            count_q    <= 7'd0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            mode_set_q <= mode_set_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            count_q    <= count_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign spi_tx_valid = valid_q;
    assign spi_tx_byte  = byte_q;
    assign spi_tx_count = count_q;
    assign i_ack        = ack_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sram_writer.sv
// Directed bench for sram_writer (PAGE_BITS = 5) with a simple SPI master
// responder and a byte-stream source.
module tb_sram_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] page_no;
    logic [7:0]  nbytes;
    logic        start;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        i_ack;
    logic        busy;
    logic        done;
    logic        spi_tx_ready = 1'b1;
    logic        spi_tx_valid;
    logic [7:0]  spi_tx_byte;
    logic [6:0]  spi_tx_count;

    sram_writer #(.PAGE_BITS(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .page_no      (page_no),
        .nbytes       (nbytes),
        .start        (start),
        .i_byte       (i_byte),
        .i_valid      (i_valid),
        .i_ack        (i_ack),
        .busy         (busy),
        .done         (done),
        .spi_tx_ready (spi_tx_ready),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_count (spi_tx_count)
    );

    always #5 clk = ~clk;

    // Source: presents src_mem[src_idx]; advances on each ack.
    logic [7:0] src_mem [256];
    logic [7:0] src_idx = 8'd0;
    logic       src_en;
    assign i_byte  = src_mem[src_idx];
    assign i_valid = src_en;

    // Master model and monitors.
    logic [7:0] log_b [$];
    logic [6:0] log_c [$];
    int         hold = 0;
    int         ack_total = 0;
    int         done_total = 0;
    int         dbl_valid = 0;
    int         ack_no_valid = 0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) begin
        if (spi_tx_valid && spi_tx_ready) begin
            log_b.push_back(spi_tx_byte);
            log_c.push_back(spi_tx_count);
            spi_tx_ready <= 1'b0;
            hold         <= 3;
        end else if (hold > 0) begin
            hold <= hold - 1;
            if (hold == 1) spi_tx_ready <= 1'b1;
        end
        if (i_ack) begin
            src_idx   <= src_idx + 8'd1;
            ack_total <= ack_total + 1;
        end
        if (i_ack && !spi_tx_valid) ack_no_valid <= ack_no_valid + 1;
        if (done) done_total <= done_total + 1;
        if (spi_tx_valid && prev_valid) dbl_valid <= dbl_valid + 1;
        prev_valid <= spi_tx_valid;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_b [64];
    logic [6:0] exp_c [64];

    // Compare n logged bytes from base against exp_b/exp_c.
    task automatic check_seq(input string tag, input int base, input int n);
        check($sformatf("%s_len", tag), 32'(log_b.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < log_b.size()) begin
                check($sformatf("%s_b%0d", tag, i), {24'h0, log_b[base + i]}, {24'h0, exp_b[i]});
                check($sformatf("%s_c%0d", tag, i), {25'h0, log_c[base + i]}, {25'h0, exp_c[i]});
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 32'(log_b.size()), 32'(base + i + 1));
            end
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
        check({tag, "_busy_fall"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic pulse_start(input logic [15:0] pg, input logic [7:0] nb);
        page_no = pg;
        nbytes  = nb;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    int base;
    int a0;
    int d0;
    int k;
    int gap_valid;
    int gap_idle;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        src_en  = 1'b0;
        page_no = 16'h0;
        nbytes  = 8'h0;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_valid", {31'h0, spi_tx_valid}, 32'h0);
        check("rst_byte", {24'h0, spi_tx_byte}, 32'h0);
        check("rst_count", {25'h0, spi_tx_count}, 32'h0);
        check("rst_ack", {31'h0, i_ack}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: first write after reset, page 3, 4 bytes A1..A4
        base = log_b.size();
        a0 = ack_total;
        d0 = done_total;
        for (int i = 0; i < 4; i++) src_mem[8'(src_idx + 8'(i))] = 8'hA1 + 8'(i);
        src_en  = 1'b1;
        page_no = 16'h0003;
        nbytes  = 8'd4;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_busy_rise", {31'h0, busy}, 32'h1);
        check("t1_no_valid_yet", {31'h0, spi_tx_valid}, 32'h0);
        @(negedge clk);
        check("t1_latency_valid", {31'h0, spi_tx_valid}, 32'h1);
        check("t1_first_byte", {24'h0, spi_tx_byte}, 32'h01);
        wait_done("t1", 500);
        repeat (2) @(negedge clk);
        exp_b[0] = 8'h01; exp_c[0] = 7'd2;
        exp_b[1] = 8'h40; exp_c[1] = 7'd2;
        exp_b[2] = 8'h02; exp_b[3] = 8'h00; exp_b[4] = 8'h00; exp_b[5] = 8'h60;
        exp_b[6] = 8'hA1; exp_b[7] = 8'hA2; exp_b[8] = 8'hA3; exp_b[9] = 8'hA4;
        for (int i = 2; i < 10; i++) exp_c[i] = 7'd8;
        check_seq("t1", base, 10);
        check("t1_acks", 32'(ack_total - a0), 32'd4);
        check("t1_dones", 32'(done_total - d0), 32'd1);

        // T2: page 0x07FF, 32 bytes, no WRMR; stray start while busy
        base = log_b.size();
        a0 = ack_total;
        d0 = done_total;
        for (int i = 0; i < 32; i++) src_mem[8'(src_idx + 8'(i))] = 8'h10 + 8'(i);
        pulse_start(16'h07FF, 8'd32);
        repeat (3) @(negedge clk);
        pulse_start(16'h1234, 8'd1);
        wait_done("t2", 2000);
        repeat (2) @(negedge clk);
        exp_b[0] = 8'h02; exp_b[1] = 8'h00; exp_b[2] = 8'hFF; exp_b[3] = 8'hE0;
        for (int i = 0; i < 32; i++) exp_b[4 + i] = 8'h10 + 8'(i);
        for (int i = 0; i < 36; i++) exp_c[i] = 7'd36;
        check_seq("t2", base, 36);
        check("t2_acks", 32'(ack_total - a0), 32'd32);
        check("t2_dones", 32'(done_total - d0), 32'd1);

        // T3: nbytes=200 clamps to 32; 10-cycle source gap mid-data
        base = log_b.size();
        a0 = ack_total;
        for (int i = 0; i < 32; i++) src_mem[8'(src_idx + 8'(i))] = 8'h40 + 8'(i);
        pulse_start(16'h0001, 8'd200);
        k = 0;
        while (ack_total - a0 < 5 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t3_reach_gap", 32'(ack_total - a0), 32'd5);
        src_en = 1'b0;
        gap_valid = 0;
        gap_idle = 0;
        for (int i = 0; i < 10; i++) begin
            if (spi_tx_valid) gap_valid++;
            if (!busy) gap_idle++;
            @(negedge clk);
        end
        check("t3_gap_valid", 32'(gap_valid), 32'd0);
        check("t3_gap_busy_low", 32'(gap_idle), 32'd0);
        src_en = 1'b1;
        wait_done("t3", 2000);
        repeat (2) @(negedge clk);
        exp_b[0] = 8'h02; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h20;
        for (int i = 0; i < 32; i++) exp_b[4 + i] = 8'h40 + 8'(i);
        for (int i = 0; i < 36; i++) exp_c[i] = 7'd36;
        check_seq("t3", base, 36);
        check("t3_acks", 32'(ack_total - a0), 32'd32);

        // T4: nbytes=0 completes without bus activity
        base = log_b.size();
        pulse_start(16'h0009, 8'd0);
        check("t4_done_pulse", {31'h0, done}, 32'h1);
        check("t4_busy_low", {31'h0, busy}, 32'h0);
        check("t4_no_valid", {31'h0, spi_tx_valid}, 32'h0);
        @(negedge clk);
        check("t4_done_once", {31'h0, done}, 32'h0);
        check("t4_busy_still_low", {31'h0, busy}, 32'h0);
        repeat (5) @(negedge clk);
        check("t4_no_bytes", 32'(log_b.size() - base), 32'd0);

        // T5: reset during ADDR_M aborts; next write re-sends WRMR
        src_en = 1'b0;
        base = log_b.size();
        pulse_start(16'h0005, 8'd2);
        k = 0;
        while (log_b.size() - base < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t5_reach_addr_m", 32'(log_b.size() - base), 32'd2);
        check("t5_busy_before", {31'h0, busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        check("t5_rst_count", {25'h0, spi_tx_count}, 32'h0);
        check("t5_rst_byte", {24'h0, spi_tx_byte}, 32'h0);
        check("t5_rst_valid", {31'h0, spi_tx_valid}, 32'h0);
        check("t5_rst_ack", {31'h0, i_ack}, 32'h0);
        check("t5_rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        base = log_b.size();
        src_mem[src_idx] = 8'h5A;
        src_en = 1'b1;
        pulse_start(16'h0002, 8'd1);
        wait_done("t6", 500);
        repeat (2) @(negedge clk);
        exp_b[0] = 8'h01; exp_c[0] = 7'd2;
        exp_b[1] = 8'h40; exp_c[1] = 7'd2;
        exp_b[2] = 8'h02; exp_b[3] = 8'h00; exp_b[4] = 8'h00; exp_b[5] = 8'h40;
        exp_b[6] = 8'h5A;
        for (int i = 2; i < 7; i++) exp_c[i] = 7'd5;
        check_seq("t6", base, 7);

        // Global protocol properties
        check("valid_back_to_back", 32'(dbl_valid), 32'd0);
        check("ack_without_valid", 32'(ack_no_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_writer.md
# sram_writer

Page writer for the external serial SRAM, the write-side counterpart of the page reader. It takes a page number and byte count, then issues an SPI WRITE transaction (command, 24-bit address, data) through the shared byte-level SPI master. Data comes from a byte-stream source through a valid/ack handshake. It sits beside the page reader on the SPI master's transmit port; arbitration between the two is external, and `busy` is the grant-hold signal.

## Interface
- PAGE_BITS, default 5, log2 of page size in bytes (PAGE_BYTES = 2^PAGE_BITS). Legal range is 1..6.
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- page_no  in  16  page to write; sampled when `start` is accepted.
- nbytes  in  8  number of data bytes to write; sampled when `start` is accepted.
- start  in  1  request; accepted only in IDLE.
- i_byte  in  8  data byte from the source.
- i_valid  in  1  `i_byte` is valid.
- i_ack  out  1  one-cycle pulse: `i_byte` has been consumed.
- busy  out  1  high from the cycle after `start` is accepted until `done`.
- done  out  1  one-cycle pulse when the transaction has fully shifted out.
- spi_tx_ready  in  1  SPI master can accept a byte.
- spi_tx_valid  out  1  one-cycle pulse that offers `spi_tx_byte`.
- spi_tx_byte  out  8  byte to transmit.
- spi_tx_count  out  7  total bytes in the current chip-select frame; loaded with the first byte of each frame.

## Operation
- Commands: WRMR = 0x01, mode SEQUENTIAL = 0x40, WRITE = 0x02.
- Length rules:
  - Effective length n = min(nbytes, PAGE_BYTES).
  - If n = 0: no SPI activity. `done` pulses 1 cycle after `start`, and `busy` stays low.
- Address is 24 bits: {8'h00, page_no[15-PAGE_BITS:0], PAGE_BITS zeros}.
- The internal flag `mode_set` is cleared by reset and set after the first WRMR frame.
- State machine:
  - IDLE: on `start` with n>0, latch address and n, set `busy`, go to START.
  - START: on `spi_tx_ready`:
    - if `!mode_set`, send WRMR with count 2 and go to MODE.
    - otherwise send WRITE with count n+4 and go to ADDR_H.
  - MODE: on ready, send 0x40, set `mode_set`, go to CMD.
  - CMD: on ready, send WRITE with count n+4, go to ADDR_H.
  - ADDR_H, ADDR_M, ADDR_L: on ready, send address bits [23:16], [15:8], [7:0] in turn. ADDR_L goes to DATA.
  - DATA: on `spi_tx_ready && i_valid`:
    - send `i_byte`, pulse `i_ack`, decrement the remaining count.
    - after the byte that makes remaining = 0, go to DRAIN.
  - DRAIN: wait for `spi_tx_ready` high, which means the last byte has shifted out. Then pulse `done`, drop `busy`, go to IDLE.
- The block discards received bytes; SPI receive lines are not connected.
- `start` is ignored while not in IDLE.
- If `i_valid` is low in DATA, the block stalls indefinitely with chip select held. Sourcing data in time is the client's responsibility.

## Timing
- Reset values: spi_tx_valid=0, spi_tx_byte=0, spi_tx_count=0, i_ack=0, busy=0, done=0, mode_set=0, state=IDLE.
- Reset asserted mid-transaction aborts immediately with the values above. The next transaction re-sends WRMR.
- `spi_tx_valid` is never high on two consecutive cycles. Every send state first drives valid=0, then re-arms when it sees ready. The SPI master drops ready the cycle after it accepts a byte.
- `spi_tx_byte` and `spi_tx_count` are registered and change only in the cycle `spi_tx_valid` is set.
- `i_ack` is coincident with the `spi_tx_valid` that carries that byte.
- `busy` is asserted the cycle after `start`. `busy` falls and `done` pulses in the same cycle.
- Minimum start-to-first-SPI-byte latency is 2 cycles (with ready held high).
- Bytes on SPI per transaction:
  - first transaction after reset: 2 + 4 + n.
  - later transactions: 4 + n.
- Maximum count is 4 + 64 = 68, which fits 7 bits.

## Test plan
- First write after reset, PAGE_BITS=5, page_no=0x0003, nbytes=4, data A1..A4.
  - SPI frame 1: 01,40 with count 2.
  - SPI frame 2: 02,00,00,60,A1,A2,A3,A4 with count 8.
  - Exactly 4 `i_ack` pulses; `done` pulses once.
- Second write with page_no=0x07FF, nbytes=32: no WRMR; bytes 02,00,FF,E0 then 32 data bytes, count 36.
- nbytes=200 with PAGE_BITS=5: clamped to 32 data bytes, count 36. nbytes=0: no `spi_tx_valid`, `done` pulses 1 cycle after `start`, `busy` stays 0.
- Hold `i_valid` low for 10 cycles mid-data: no `spi_tx_valid` during the gap. The byte stream resumes intact and `busy` stays high.
- Assert reset_n=0 during ADDR_M: all outputs reach reset values immediately. The next write begins with WRMR again.
- `start` pulsed while busy: ignored, with no change in the SPI byte sequence or count.
